addern_complex_pipe: RTL and testbench
======================================

// Module: adderN_complex_pipe
// PURPOSE
//  Pipelined N-input complex fixed-point adder tree for the convolution datapath; successor to the
//  3-input combinational complex adder. Sums N complex Q(QI.QF) samples per beat, with a valid/ready
//  handshake, a registered tree level per stage, optional saturation back to input width and a
//  per-beat plus sticky overflow flag. Sits between the complex multipliers and the accumulator.
// PARAMETERS
//  QI   3  integer bits incl. sign position index; sample range bit QI..-QF, W_IN = QI+QF+1
//  QF   3  fraction bits
//  N    3  number of complex inputs summed per beat, 2..16
//  SAT  0  0 = full-growth output (W_OUT = W_IN+G); 1 = saturate to W_IN (W_OUT = W_IN)
//  derived: G = clog2(N); STAGES = G; binary point fixed, output keeps QF fraction bits
// PORTS
//  clk          in   1          rising-edge clock
//  rst_n        in   1          synchronous reset, active low
//  in_valid     in   1          input beat valid
//  in_ready     out  1          block can accept a beat this cycle
//  a_re_flat    in   N*W_IN     real parts, channel k at [k*W_IN +: W_IN], two's complement
//  a_im_flat    in   N*W_IN     imaginary parts, same packing
//  out_valid    out  1          sum valid
//  out_ready    in   1          downstream accepts sum
//  d_re         out  W_OUT      real sum, signed, QF fraction bits
//  d_im         out  W_OUT      imaginary sum
//  ovf          out  1          this beat saturated (re or im); qualified by out_valid
//  ovf_sticky   out  1          set by any accepted saturated output, held until ovf_clr
//  ovf_clr      in   1          clears ovf_sticky
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): all pipeline registers and valid bits 0; out_valid=0, d_re=d_im=0,
//    ovf=0, ovf_sticky=0. Reset mid-operation discards all in-flight beats; no partial output.
//  - stall = out_valid & ~out_ready; in_ready = ~stall (combinational). On stall every stage holds
//    data and valid; no beat dropped or duplicated. Input accepted when in_valid & in_ready.
//  - Tree: level l pairs elements 2i,2i+1 and sign-extends result 1 bit; odd leftover element passes
//    through sign-extended by 1 bit. Each level registered. Real and imag trees identical, independent.
//  - Latency: STAGES cycles accept->out_valid with no stall (N=3: 2; N=2: 1; N=16: 4). Throughput 1/clk.
//  - Bubbles (in_valid=0) propagate as invalid stages; stage registers may load but valid bits stay 0.
//  - Full-growth sum exact: |sum| <= N*2^QI fits W_IN+G, never wraps.
//  - SAT=0: d = full sum; ovf and ovf_sticky tie to 0.
//  - SAT=1: saturation in last stage: sum > max(W_IN) -> 2^(W_IN-1)-1; sum < min -> -2^(W_IN-1);
//    ovf = re_sat | im_sat, registered with d.
//  - ovf_sticky set when out_valid & out_ready & ovf; ovf_clr clears; set wins on same-cycle clr+set.
//  - Outputs stable while stall; d/ovf don't-care-but-held when out_valid=0 (last value kept).
// TESTING  (QI=3, QF=3: W_IN=7, LSB 0.125; N=3 -> G=2)
//  1 reset: drive rst_n=0 two cycles with in_valid=1 -> out_valid=0, d=0, ovf_sticky=0 after release.
//  2 SAT=0, out_ready=1: re={63,63,63} im={-64,-64,-64} -> 2 cycles later d_re=189 (23.625),
//    d_im=-192 (-24.0), ovf=0; W_OUT=9.
//  3 SAT=1 same stimulus -> d_re=63, d_im=-64, ovf=1, ovf_sticky=1; next beat re={1,2,-3} -> d_re=0, ovf=0.
//  4 backpressure: stream 8 beats re={k,0,0} k=0..7, out_ready low cycles 3..5 -> in_ready low same
//    cycles, all 8 sums out in order 0..7, none repeated.
//  5 SAT=1: ovf_clr=1 in same cycle as accepted saturating beat -> ovf_sticky stays 1; ovf_clr alone -> 0.
//  6 rst_n=0 for one cycle with 2 beats in flight -> no out_valid for those beats; next beat after
//    release arrives with normal latency; N=2 and N=16 builds rerun test 2 with latency 1 and 4.

Source files
------------

// File: rtl/addern_complex_pipe_if.sv
// Handshake and data bus of the pipelined N-input complex adder.
// slave side is the adder, master side is whoever feeds and drains it.
interface addern_complex_pipe_if #(
  parameter int N     = 3,
  parameter int W_IN  = 7,
  parameter int W_OUT = 9
);
  logic                 in_valid;
  logic                 in_ready;
  logic [N*W_IN-1:0]    a_re_flat;
  logic [N*W_IN-1:0]    a_im_flat;
  logic                 out_valid;
  logic                 out_ready;
  logic [W_OUT-1:0]     d_re;
  logic [W_OUT-1:0]     d_im;
  logic                 ovf;
  logic                 ovf_sticky;
  logic                 ovf_clr;

  modport master (
    output in_valid, a_re_flat, a_im_flat, out_ready, ovf_clr,
    input  in_ready, out_valid, d_re, d_im, ovf, ovf_sticky
  );

  modport slave (
    input  in_valid, a_re_flat, a_im_flat, out_ready, ovf_clr,
    output in_ready, out_valid, d_re, d_im, ovf, ovf_sticky
  );
endinterface

// File: rtl/addern_complex_pipe.sv
// Pipelined N-input complex fixed-point adder tree.
// One registered tree level per stage, last level feeds the output register
// (optionally saturated back to input width). Whole pipe stalls as one unit.

// Pair adder for one tree node: sign-extend both operands by one bit and add.
module addern_complex_pipe_node #(
  parameter int WI = 7
) (
  input  logic [WI-1:0] a_re,
  input  logic [WI-1:0] a_im,
  input  logic [WI-1:0] b_re,
  input  logic [WI-1:0] b_im,
  output logic [WI:0]   s_re,
  output logic [WI:0]   s_im
);
  assign s_re = {a_re[WI-1], a_re} + {b_re[WI-1], b_re};
  assign s_im = {a_im[WI-1], a_im} + {b_im[WI-1], b_im};
endmodule

module addern_complex_pipe #(
  parameter int QI  = 3,
  parameter int QF  = 3,
  parameter int N   = 3,
  parameter int SAT = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  addern_complex_pipe_if.slave bus
);
  localparam int W_IN   = QI + QF + 1;
  localparam int G      = $clog2(N);
  localparam int STAGES = G;
  localparam int W_SUM  = W_IN + G;
  localparam int W_OUT  = (SAT != 0) ? W_IN : W_SUM;

  // element count after l tree levels (odd leftovers carried upward)
  function automatic int lvl_cnt(input int l);
    return (N + (1 << l) - 1) >> l;
  endfunction

  logic                   stall;
  logic [STAGES:1]        vld_q;
  logic [STAGES:0]        vld_pipe;
  logic [N-1:0][W_IN-1:0] in_re;
  logic [N-1:0][W_IN-1:0] in_im;
  logic [W_SUM-1:0]       sum_re;
  logic [W_SUM-1:0]       sum_im;
  logic [W_OUT-1:0]       res_re;
  logic [W_OUT-1:0]       res_im;
  logic                   res_ovf;
  logic [W_OUT-1:0]       d_re_q;
  logic [W_OUT-1:0]       d_im_q;
  logic                   ovf_q;
  logic                   sticky_q;

  // vld_pipe[0] is the incoming beat, vld_pipe[s] the valid of stage s
  assign vld_pipe     = {vld_q, bus.in_valid};
  assign stall        = vld_pipe[STAGES] & ~bus.out_ready;
  assign bus.in_ready = ~stall;

  // flat bus already packs channel k at [k*W_IN +: W_IN]
  assign in_re = bus.a_re_flat;
  assign in_im = bus.a_im_flat;

  // valid shift register; frozen together with the data on stall
  always_ff @(posedge clk) begin
    if (!rst_n)      vld_q <= '0;
    else if (!stall) vld_q <= vld_pipe[STAGES-1:0];
  end

  for (genvar l = 1; l <= STAGES; l++) begin : g_lvl
    localparam int NI = lvl_cnt(l - 1);
    localparam int NO = lvl_cnt(l);
    localparam int WI = W_IN + l - 1;

    logic [NI-1:0][WI-1:0] x_re;
    logic [NI-1:0][WI-1:0] x_im;
    logic [NO-1:0][WI:0]   s_re;
    logic [NO-1:0][WI:0]   s_im;

    if (l == 1) begin : g_src_in
      assign x_re = in_re;
      assign x_im = in_im;
    end else begin : g_src_lvl
      assign x_re = g_lvl[l-1].g_reg.q_re;
      assign x_im = g_lvl[l-1].g_reg.q_im;
    end

    for (genvar i = 0; i < NI / 2; i++) begin : g_node
      addern_complex_pipe_node #(.WI(WI)) u_node (
        .a_re (x_re[2*i]),
        .a_im (x_im[2*i]),
        .b_re (x_re[2*i+1]),
        .b_im (x_im[2*i+1]),
        .s_re (s_re[i]),
        .s_im (s_im[i])
      );
    end

    // odd element rides up one level, sign-extended to keep widths aligned
    if (NI % 2 != 0) begin : g_odd
      assign s_re[NO-1] = {x_re[NI-1][WI-1], x_re[NI-1]};
      assign s_im[NO-1] = {x_im[NI-1][WI-1], x_im[NI-1]};
    end

    // inner level register; the last level is registered by the output stage
    if (l < STAGES) begin : g_reg
      logic [NO-1:0][WI:0] q_re;
      logic [NO-1:0][WI:0] q_im;

      // bubbles may load here, only vld_pipe qualifies the contents
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          q_re <= '0;
          q_im <= '0;
        end else if (!stall) begin
          q_re <= s_re;
          q_im <= s_im;
        end
      end
    end
  end

  assign sum_re = g_lvl[STAGES].s_re[0];
  assign sum_im = g_lvl[STAGES].s_im[0];

  if (SAT != 0) begin : g_sat
    logic re_sat;
    logic im_sat;

    // returns {saturated, value}; value fits when the G+1 top bits agree
    function automatic logic [W_IN:0] clip(input logic [W_SUM-1:0] v);
      logic fits;
      fits = (v[W_SUM-1:W_IN-1] == {(G+1){v[W_SUM-1]}});
      if (fits)            return {1'b0, v[W_IN-1:0]};
      else if (v[W_SUM-1]) return {1'b1, 1'b1, {(W_IN-1){1'b0}}};
      else                 return {1'b1, 1'b0, {(W_IN-1){1'b1}}};
    endfunction

    assign {re_sat, res_re} = clip(sum_re);
    assign {im_sat, res_im} = clip(sum_im);
    assign res_ovf          = re_sat | im_sat;
  end else begin : g_full
    assign res_re  = sum_re;
    assign res_im  = sum_im;
    assign res_ovf = 1'b0;
  end

  // output register loads only real beats so d/ovf keep the last sum between beats
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d_re_q <= '0;
      d_im_q <= '0;
      ovf_q  <= 1'b0;
    end else if (!stall && vld_pipe[STAGES-1]) begin
      d_re_q <= res_re;
      d_im_q <= res_im;
      ovf_q  <= res_ovf;
    end
  end

  // sticky overflow: set on a delivered saturated beat, set beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (!rst_n)                                          sticky_q <= 1'b0;
    else if (vld_pipe[STAGES] && bus.out_ready && ovf_q) sticky_q <= 1'b1;
    else if (bus.ovf_clr)                                sticky_q <= 1'b0;
  end

  assign bus.out_valid  = vld_pipe[STAGES];
  assign bus.d_re       = d_re_q;
  assign bus.d_im       = d_im_q;
  assign bus.ovf        = ovf_q;
  assign bus.ovf_sticky = sticky_q;
endmodule

// File: tb/tb_addern_complex_pipe.sv
// Directed bench: four builds share one stimulus source.
//   u0: N=3 SAT=0 (W_OUT 9)   u1: N=3 SAT=1 (W_OUT 7)
//   u2: N=2 SAT=0 (W_OUT 8)   u3: N=16 SAT=0 (W_OUT 11)
module tb_addern_complex_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, in_valid, out_ready, ovf_clr;
  logic [6:0] ch_re [16];
  logic [6:0] ch_im [16];
  logic [16*7-1:0] flat_re, flat_im;

  always_comb begin
    flat_re = '0;
    flat_im = '0;
    for (int k = 0; k < 16; k++) begin
      flat_re[k*7 +: 7] = ch_re[k];
      flat_im[k*7 +: 7] = ch_im[k];
    end
  end

  addern_complex_pipe_if #(.N(3),  .W_IN(7), .W_OUT(9))  b0 ();
  addern_complex_pipe_if #(.N(3),  .W_IN(7), .W_OUT(7))  b1 ();
  addern_complex_pipe_if #(.N(2),  .W_IN(7), .W_OUT(8))  b2 ();
  addern_complex_pipe_if #(.N(16), .W_IN(7), .W_OUT(11)) b3 ();

  assign b0.in_valid = in_valid;  assign b0.out_ready = out_ready;  assign b0.ovf_clr = ovf_clr;
  assign b1.in_valid = in_valid;  assign b1.out_ready = out_ready;  assign b1.ovf_clr = ovf_clr;
  assign b2.in_valid = in_valid;  assign b2.out_ready = out_ready;  assign b2.ovf_clr = ovf_clr;
  assign b3.in_valid = in_valid;  assign b3.out_ready = out_ready;  assign b3.ovf_clr = ovf_clr;
  assign b0.a_re_flat = flat_re[20:0];  assign b0.a_im_flat = flat_im[20:0];
  assign b1.a_re_flat = flat_re[20:0];  assign b1.a_im_flat = flat_im[20:0];
  assign b2.a_re_flat = flat_re[13:0];  assign b2.a_im_flat = flat_im[13:0];
  assign b3.a_re_flat = flat_re;        assign b3.a_im_flat = flat_im;

  addern_complex_pipe #(.QI(3), .QF(3), .N(3),  .SAT(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  addern_complex_pipe #(.QI(3), .QF(3), .N(3),  .SAT(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  addern_complex_pipe #(.QI(3), .QF(3), .N(2),  .SAT(0)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  addern_complex_pipe #(.QI(3), .QF(3), .N(16), .SAT(0)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3));

  int n_run  = 0;
  int n_fail = 0;
  int lat [4];
  int q0 [$];
  logic mon_en = 1'b0;

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input logic [6:0] r, input logic [6:0] i);
    for (int k = 0; k < 16; k++) begin
      ch_re[k] = r;
      ch_im[k] = i;
    end
  endtask

  // one-beat send; lat[] = edges from drive until out_valid first seen
  task automatic send_measure(input int maxc);
    for (int i = 0; i < 4; i++) lat[i] = -1;
    in_valid = 1'b1;
    for (int c = 1; c <= maxc; c++) begin
      tick;
      in_valid = 1'b0;
      if (lat[0] < 0 && b0.out_valid) lat[0] = c;
      if (lat[1] < 0 && b1.out_valid) lat[1] = c;
      if (lat[2] < 0 && b2.out_valid) lat[2] = c;
      if (lat[3] < 0 && b3.out_valid) lat[3] = c;
    end
  endtask

  // transfers happen at the next rising edge; capture them mid-cycle
  always @(negedge clk)
    if (mon_en && b0.out_valid && b0.out_ready) q0.push_back(int'($signed(b0.d_re)));

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, cyc, nv0, nv3;
    logic acc;

    // reset held two edges with in_valid high
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1; ovf_clr = 1'b0;
    set_all(7'd63, 7'h40);
    tick; tick;
    rst_n = 1'b1; in_valid = 1'b0;
    chk("rst_vld0",    b0.out_valid, 0);
    chk("rst_dre0",    $signed(b0.d_re), 0);
    chk("rst_dim0",    $signed(b0.d_im), 0);
    chk("rst_vld3",    b3.out_valid, 0);
    chk("rst_ovf1",    b1.ovf, 0);
    chk("rst_sticky1", b1.ovf_sticky, 0);
    chk("rst_rdy0",    b0.in_ready, 1);

    // extreme inputs: re all +63, im all -64
    send_measure(8);
    chk("t2_lat0", lat[0], 2);
    chk("t2_lat1", lat[1], 2);
    chk("t2_lat2", lat[2], 1);
    chk("t2_lat3", lat[3], 4);
    chk("t2_dre0", $signed(b0.d_re), 189);
    chk("t2_dim0", $signed(b0.d_im), -192);
    chk("t2_ovf0", b0.ovf, 0);
    chk("t2_sticky0", b0.ovf_sticky, 0);
    chk("t2_dre1", $signed(b1.d_re), 63);
    chk("t2_dim1", $signed(b1.d_im), -64);
    chk("t2_ovf1", b1.ovf, 1);
    chk("t2_sticky1", b1.ovf_sticky, 1);
    chk("t2_dre2", $signed(b2.d_re), 126);
    chk("t2_dim2", $signed(b2.d_im), -128);
    chk("t2_dre3", $signed(b3.d_re), 1008);
    chk("t2_dim3", $signed(b3.d_im), -1024);
    chk("t2_nodup0", b0.out_valid, 0);

    // in-range beat: re {1,2,-3}, im {5,-2,4}
    set_all(7'd0, 7'd0);
    ch_re[0] = 7'd1; ch_re[1] = 7'd2; ch_re[2] = 7'h7D;
    ch_im[0] = 7'd5; ch_im[1] = 7'h7E; ch_im[2] = 7'd4;
    send_measure(6);
    chk("t3_dre1", $signed(b1.d_re), 0);
    chk("t3_dim1", $signed(b1.d_im), 7);
    chk("t3_ovf1", b1.ovf, 0);
    chk("t3_sticky1", b1.ovf_sticky, 1);
    chk("t3_dim0", $signed(b0.d_im), 7);
    chk("t3_dre2", $signed(b2.d_re), 3);
    chk("t3_dim2", $signed(b2.d_im), 3);
    chk("t3_dre3", $signed(b3.d_re), 0);

    // sticky: clear alone, then clear colliding with a saturated delivery
    ovf_clr = 1'b1; tick; ovf_clr = 1'b0;
    chk("t5_clr", b1.ovf_sticky, 0);
    set_all(7'd63, 7'h40);
    in_valid = 1'b1; tick; in_valid = 1'b0; tick;
    chk("t5_vld1", b1.out_valid, 1);
    ovf_clr = 1'b1; tick; ovf_clr = 1'b0;
    chk("t5_setwins", b1.ovf_sticky, 1);
    ovf_clr = 1'b1; tick; ovf_clr = 1'b0;
    chk("t5_clr2", b1.ovf_sticky, 0);
    repeat (6) tick;

    // backpressure: 8 beats re={k,0,0}, out_ready low in stream cycles 3..5
    set_all(7'd0, 7'd0);
    mon_en = 1'b1;
    k = 0; cyc = 0;
    while (k < 8 && cyc < 40) begin
      ch_re[0] = 7'(k);
      in_valid = 1'b1;
      out_ready = !(cyc >= 3 && cyc <= 5);
      #1;
      if (cyc >= 2 && cyc <= 6)
        chk($sformatf("t4_rdy_c%0d", cyc), b0.in_ready, (cyc >= 3 && cyc <= 5) ? 0 : 1);
      acc = b0.in_ready;
      @(posedge clk); #1;
      if (acc) k++;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) tick;
    mon_en = 1'b0;
    chk("t4_count", q0.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < q0.size()) chk($sformatf("t4_beat%0d", i), q0[i], i);

    // reset with two beats inside the N=16 pipe
    set_all(7'd63, 7'h40);
    in_valid = 1'b1; tick; tick;
    in_valid = 1'b0; rst_n = 1'b0; tick; rst_n = 1'b1;
    chk("t6_dre0", $signed(b0.d_re), 0);
    nv0 = 0; nv3 = 0;
    for (int c = 0; c < 8; c++) begin
      nv0 += int'(b0.out_valid);
      nv3 += int'(b3.out_valid);
      tick;
    end
    chk("t6_flush0", nv0, 0);
    chk("t6_flush3", nv3, 0);
    set_all(7'd5, 7'h7D);
    send_measure(8);
    chk("t6_lat0", lat[0], 2);
    chk("t6_lat2", lat[2], 1);
    chk("t6_lat3", lat[3], 4);
    chk("t6_dre0", $signed(b0.d_re), 15);
    chk("t6_dim0", $signed(b0.d_im), -9);
    chk("t6_dre1", $signed(b1.d_re), 15);
    chk("t6_dre3", $signed(b3.d_re), 80);
    chk("t6_dim3", $signed(b3.d_im), -48);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
